// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: FP32 field layout, exponent limits
// and the normalize/round sequencer state encoding.
package fpu_pkg;

  localparam int unsigned SIGN_W      = 1;
  localparam int unsigned EXP_FIELD_W = 8;
  localparam int unsigned FRAC_W      = 23;
  localparam int unsigned FP_W        = SIGN_W + EXP_FIELD_W + FRAC_W;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [FP_W-1:0] FP_MAX_FINITE = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_e;

endpackage

// File: rtl/fp_norm_round_if.sv
// Request/result bundle between an FPU core (master) and the normalize/round
// stage (slave).
interface fp_norm_round_if #(
  parameter int unsigned MANT_W = 48,
  parameter int unsigned EXP_W  = 10
);
  import fpu_pkg::*;

  logic              start;
  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              busy;
  logic [FP_W-1:0]   result;
  logic              overflow;
  logic              underflow;
  logic              normalized_round_done;
  logic              done_cal;

  modport master (
    output start, sign_in, exp_in, mant_in,
    input  busy, result, overflow, underflow, normalized_round_done, done_cal
  );

  modport slave (
    input  start, sign_in, exp_in, mant_in,
    output busy, result, overflow, underflow, normalized_round_done, done_cal
  );

endinterface

// File: rtl/rne_rounder.sv
// Combinational round-to-nearest-even on a 23-bit fraction with guard/sticky;
// carry flags a wrap of the 24-bit significand to 1.0.
module rne_rounder
  import fpu_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_rounded_c,
  output logic              carry_c
);

  logic inc_c;

  // Ties (guard set, nothing below) round toward an even LSB.
  assign inc_c = guard & (sticky | frac[0]);
  assign {carry_c, frac_rounded_c} = {1'b0, frac} + (FRAC_W+1)'(inc_c);

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalize-and-round stage: one normalization shift per cycle,
// then RNE rounding and overflow/underflow clamping into an FP32 result.
module fp_norm_round
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_W = 48,
  parameter int unsigned EXP_W  = 10
) (
  input  logic           clk,
  input  logic           rstn,
  fp_norm_round_if.slave bus
);

  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
  localparam logic signed [EXP_W-1:0] EXP_OVF  = EXP_W'(EXP_MAX);

  norm_state_e              state;
  logic                     sign_q;
  logic signed [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0]        mant_q;
  logic                     sticky_q;

  logic [FRAC_W-1:0]        frac_c;
  logic                     guard_c;
  logic                     sticky_c;
  logic [FRAC_W-1:0]        frac_rnd_c;
  logic                     carry_c;
  logic signed [EXP_W-1:0]  exp_rnd_c;
  logic                     ovf_c;
  logic                     unf_c;

  // Rounding view of the normalized mantissa (hidden one at MANT_W-2).
  assign frac_c   = mant_q[MANT_W-3 -: FRAC_W];
  assign guard_c  = mant_q[MANT_W-26];
  assign sticky_c = (|mant_q[MANT_W-27:0]) | sticky_q;

  rne_rounder u_rne (
    .frac           (frac_c),
    .guard          (guard_c),
    .sticky         (sticky_c),
    .frac_rounded_c (frac_rnd_c),
    .carry_c        (carry_c)
  );

  assign exp_rnd_c = carry_c ? exp_q + EXP_ONE : exp_q;
  assign ovf_c     = (exp_rnd_c >= EXP_OVF);
  assign unf_c     = (exp_rnd_c <= EXP_ZERO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                     <= ST_IDLE;
      sign_q                    <= 1'b0;
      exp_q                     <= EXP_ZERO;
      mant_q                    <= '0;
      sticky_q                  <= 1'b0;
      bus.busy                  <= 1'b0;
      bus.result                <= '0;
      bus.overflow              <= 1'b0;
      bus.underflow             <= 1'b0;
      bus.normalized_round_done <= 1'b0;
      bus.done_cal              <= 1'b0;
    end else begin
      bus.normalized_round_done <= 1'b0;
      bus.done_cal              <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sign_q   <= bus.sign_in;
            exp_q    <= $signed(bus.exp_in);
            mant_q   <= bus.mant_in;
            sticky_q <= 1'b0;
            // A zero magnitude needs no normalization: signed zero right away.
            if (bus.mant_in == '0) begin
              state                     <= ST_DONE;
              bus.busy                  <= 1'b0;
              bus.result                <= {bus.sign_in, (FP_W-1)'(0)};
              bus.overflow              <= 1'b0;
              bus.underflow             <= 1'b0;
              bus.normalized_round_done <= 1'b1;
              bus.done_cal              <= 1'b1;
            end else begin
              state    <= ST_NORM;
              bus.busy <= 1'b1;
            end
          end else begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end

        ST_NORM: begin
          if (mant_q[MANT_W-1]) begin
            mant_q   <= {1'b0, mant_q[MANT_W-1:1]};
            exp_q    <= exp_q + EXP_ONE;
            sticky_q <= sticky_q | mant_q[0];
          end else if (!mant_q[MANT_W-2]) begin
            mant_q <= {mant_q[MANT_W-2:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
          end else begin
            state <= ST_ROUND;
          end
        end

        ST_ROUND: begin
          state                     <= ST_DONE;
          bus.busy                  <= 1'b0;
          exp_q                     <= exp_rnd_c;
          bus.overflow              <= ovf_c;
          bus.underflow             <= unf_c;
          bus.normalized_round_done <= 1'b1;
          bus.done_cal              <= 1'b1;
          if (ovf_c)
            bus.result <= {sign_q, FP_MAX_FINITE[FP_W-2:0]};
          else if (unf_c)
            bus.result <= '0;
          else
            bus.result <= {sign_q, exp_rnd_c[EXP_FIELD_W-1:0], frac_rnd_c};
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: expected results queued at each start and
// checked with latency when the done pulse appears.
module tb_fp_norm_round;

  localparam int unsigned MANT_W = 48;
  localparam int unsigned EXP_W  = 10;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          due;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   spur_cnt;
  exp_t sb[$];

  fp_norm_round_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  fp_norm_round #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued op.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (bus.normalized_round_done === 1'b1 || bus.done_cal === 1'b1) begin
      if (sb.size() == 0) begin
        spur_cnt++;
      end else begin
        e = sb.pop_front();
        check({e.tag, "_result"},    bus.result, e.res);
        check({e.tag, "_overflow"},  32'(bus.overflow), 32'(e.ovf));
        check({e.tag, "_underflow"}, 32'(bus.underflow), 32'(e.unf));
        check({e.tag, "_done_cal"},  32'(bus.done_cal), 32'(bus.normalized_round_done));
        check({e.tag, "_latency"},   32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; the start edge is the next posedge.
  task automatic pulse_start(input logic s, input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    bus.start   = 1'b1;
    bus.sign_in = s;
    bus.exp_in  = e;
    bus.mant_in = m;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic issue(input string tag, input logic s, input logic [EXP_W-1:0] e,
                       input logic [MANT_W-1:0] m, input logic [31:0] res,
                       input logic ovf, input logic unf, input int lat);
    exp_t x;
    x.tag = tag; x.res = res; x.ovf = ovf; x.unf = unf; x.due = cyc + lat;
    sb.push_back(x);
    pulse_start(s, e, m);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_result"},    bus.result, 32'h0);
    check({tag, "_overflow"},  32'(bus.overflow), 32'd0);
    check({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
    check({tag, "_done"},      32'(bus.normalized_round_done), 32'd0);
    check({tag, "_done_cal"},  32'(bus.done_cal), 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; spur_cnt = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.sign_in = 1'b0; bus.exp_in = '0; bus.mant_in = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    issue("norm",       1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 1'b0, 1'b0, 3);
    drain("norm");
    issue("carry_pos",  1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 1'b0, 1'b0, 4);
    drain("carry_pos");
    issue("rnd_carry",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 1'b0, 1'b0, 3);
    drain("rnd_carry");
    issue("tie_even",   1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 1'b0, 1'b0, 3);
    drain("tie_even");
    issue("tie_odd",    1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 1'b0, 1'b0, 3);
    drain("tie_odd");
    issue("sticky_reg", 1'b1, 10'd127, 48'h8000_0080_0001, 32'hC000_0001, 1'b0, 1'b0, 4);
    drain("sticky_reg");
    issue("ovf_shift",  1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F7F_FFFF, 1'b1, 1'b0, 4);
    drain("ovf_shift");
    issue("ovf_round",  1'b0, 10'd254, 48'h7FFF_FFC0_0000, 32'h7F7F_FFFF, 1'b1, 1'b0, 3);
    drain("ovf_round");
    issue("ovf_neg",    1'b1, 10'd300, 48'h4000_0000_0000, 32'hFF7F_FFFF, 1'b1, 1'b0, 3);
    drain("ovf_neg");
    issue("unf_shift",  1'b0, 10'd1,   48'h2000_0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4);
    drain("unf_shift");
    issue("unf_negexp", 1'b1, 10'h3FB, 48'h4000_0000_0000, 32'h0000_0000, 1'b0, 1'b1, 3);
    drain("unf_negexp");
    issue("worst_left", 1'b0, 10'd173, 48'h0000_0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 49);
    drain("worst_left");

    // Zero, then a start in its DONE cycle, then a start while busy.
    issue("zero_neg",   1'b1, 10'd127, 48'h0,              32'h8000_0000, 1'b0, 1'b0, 1);
    issue("b2b",        1'b0, 10'd130, 48'h4000_0000_0000, 32'h4100_0000, 1'b0, 1'b0, 3);
    check("busy_in_norm", 32'(bus.busy), 32'd1);
    pulse_start(1'b1, 10'd5, 48'h8000_0000_0000);
    drain("b2b");
    check("no_spurious_b2b", 32'(spur_cnt), 32'd0);

    // Reset while a long left-normalize is in progress.
    pulse_start(1'b0, 10'd173, 48'h0000_0000_0001);
    repeat (4) @(negedge clk);
    check("busy_pre_reset", 32'(bus.busy), 32'd1);
    #2 rstn = 1'b0;
    #1 check_outputs_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    check("no_done_after_reset", 32'(spur_cnt), 32'd0);
    issue("post_reset", 1'b1, 10'd127, 48'h4000_0000_0000, 32'hBF80_0000, 1'b0, 1'b0, 3);
    drain("post_reset");
    check("no_spurious_final", 32'(spur_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
